// File: rtl/ks_sonuc_if.sv
// ks_sonuc_if: handshake and data bundle for the Kogge-Stone sum/condition
// stage. One instance carries both sides of the stage:
//   upstream   : i_valid, o_ready, i_c0, i_gk[31:0], i_p_save[31:0]
//   downstream : o_valid, i_ready, o_sum[31:0], o_carry, o_overflow, o_zero
//   control    : i_flush (synchronous pipeline flush)
// Modports:
//   slave  - the stage itself (ks_sonuc)
//   master - the surrounding pipeline (prefix network + consumer)
interface ks_sonuc_if;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic        i_c0;
  logic [31:0] i_gk;
  logic [31:0] i_p_save;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_sum;
  logic        o_carry;
  logic        o_overflow;
  logic        o_zero;

  modport slave (
    input  i_flush, i_valid, i_c0, i_gk, i_p_save, i_ready,
    output o_ready, o_valid, o_sum, o_carry, o_overflow, o_zero
  );

  modport master (
    output i_flush, i_valid, i_c0, i_gk, i_p_save, i_ready,
    input  o_ready, o_valid, o_sum, o_carry, o_overflow, o_zero
  );
endinterface

// File: rtl/ks_sonuc.sv
// ks_sonuc: final stage of the Kogge-Stone adder. Combines the resolved group
// generates with the saved bitwise propagates and carry-in to form the 32-bit
// sum plus carry/overflow/zero flags, and registers the result behind a
// valid/ready handshake.
// Parameters:
//   SKID_EN - 1: two-entry skid buffer, o_ready comes straight from a flop
//             0: single output register, o_ready = !o_valid | i_ready
// Ports:
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset
//   bus     - ks_sonuc_if.slave (flush, upstream and downstream handshakes)
module ks_sonuc #(
  parameter bit SKID_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  ks_sonuc_if.slave  bus
);

  typedef struct packed {
    logic        carry;
    logic        overflow;
    logic        zero;
    logic [31:0] sum;
  } res_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] s;
  res_t        res_new;
  res_t        main_q;
  res_t        skid_q;
  res_t        main_d;
  logic        ready_q;
  logic        ready;
  logic        in_fire;
  logic        out_fire;
  logic        load_main;
  logic        load_skid;
  logic        skid_to_main;

  // Sum bit k needs the carry into bit k, which is the group generate of
  // bit k-1; bit 0 takes the adder carry-in directly.
  always_comb begin
    s[0]    = bus.i_p_save[0] ^ bus.i_c0;
    s[31:1] = bus.i_p_save[31:1] ^ bus.i_gk[30:0];
  end

  always_comb begin
    res_new.sum      = s;
    res_new.carry    = bus.i_gk[31];
    res_new.overflow = bus.i_gk[31] ^ bus.i_gk[30];
    res_new.zero     = (s == '0);
  end

  // With the skid slot, o_ready is a flop so i_ready never reaches o_ready
  // combinationally; without it, a draining consumer frees the register in
  // the same cycle.
  assign ready    = SKID_EN ? ready_q : ((state == S_EMPTY) | bus.i_ready);
  assign in_fire  = bus.i_valid & ready;
  assign out_fire = (state != S_EMPTY) & bus.i_ready;

  always_comb begin
    state_nxt    = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (bus.i_flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_fire) begin
            load_main = 1'b1;
            state_nxt = S_BUSY;
          end
        end
        S_BUSY: begin
          if (in_fire && out_fire) begin
            load_main = 1'b1;
          end else if (in_fire) begin
            // Only reachable with the skid slot: the single-register
            // variant cannot accept while stalled.
            if (SKID_EN) begin
              load_skid = 1'b1;
              state_nxt = S_FULL;
            end else begin
              load_main = 1'b1;
            end
          end else if (out_fire) begin
            state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (out_fire) begin
            skid_to_main = 1'b1;
            state_nxt    = S_BUSY;
          end
        end
        default: state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != S_FULL);
    end
  end

  assign main_d = skid_to_main ? skid_q : res_new;

  // Flags travel with the sum; flush only clears the valid state, so the
  // data registers simply hold their last contents.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_q <= '0;
    end else if (load_main || skid_to_main) begin
      main_q <= main_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= res_new;
    end
  end

  assign bus.o_ready    = ready;
  assign bus.o_valid    = (state != S_EMPTY);
  assign bus.o_sum      = main_q.sum;
  assign bus.o_carry    = main_q.carry;
  assign bus.o_overflow = main_q.overflow;
  assign bus.o_zero     = main_q.zero;

endmodule

// File: tb/tb_ks_sonuc.sv
// tb_ks_sonuc: exercises ks_sonuc with SKID_EN=1 (index 0) and SKID_EN=0
// (index 1) side by side. Operands a, b, c0 are turned into p_save/gk
// stimulus; expected results come from plain a+b+c0 arithmetic.
module tb_ks_sonuc;

  logic        clk;
  logic        rst_n;

  logic        in_valid  [2];
  logic        flush     [2];
  logic        c0        [2];
  logic [31:0] gk        [2];
  logic [31:0] ps        [2];
  logic        out_ready [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [31:0] sum       [2];
  logic        carry     [2];
  logic        ovf       [2];
  logic        zero      [2];

  int checks   = 0;
  int failures = 0;

  logic [34:0] q0[$];
  logic [34:0] q1[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ks_sonuc_if u_bus ();
    assign u_bus.i_flush  = flush[g];
    assign u_bus.i_valid  = in_valid[g];
    assign u_bus.i_c0     = c0[g];
    assign u_bus.i_gk     = gk[g];
    assign u_bus.i_p_save = ps[g];
    assign u_bus.i_ready  = out_ready[g];
    assign in_ready[g]    = u_bus.o_ready;
    assign out_valid[g]   = u_bus.o_valid;
    assign sum[g]         = u_bus.o_sum;
    assign carry[g]       = u_bus.o_carry;
    assign ovf[g]         = u_bus.o_overflow;
    assign zero[g]        = u_bus.o_zero;

    ks_sonuc #(.SKID_EN(g == 0)) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (u_bus.slave)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] carries(input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [31:0] r;
    logic        c;
    c = ci;
    for (int k = 0; k < 32; k++) begin
      r[k] = (a[k] & b[k]) | ((a[k] ^ b[k]) & c);
      c    = r[k];
    end
    return r;
  endfunction

  // Expected {carry, overflow, zero, sum} from ordinary addition.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [32:0] t;
    logic        v;
    t = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    v = (a[31] == b[31]) && (t[31] != a[31]);
    return {t[32], v, (t[31:0] == 32'd0), t[31:0]};
  endfunction

  function automatic logic [34:0] obs(input int d);
    return {carry[d], ovf[d], zero[d], sum[d]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic put(input int d, input logic [31:0] a, input logic [31:0] b, input logic ci);
    in_valid[d] = 1'b1;
    c0[d]       = ci;
    ps[d]       = a ^ b;
    gk[d]       = carries(a, b, ci);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input logic [34:0] v);
    if (d == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic pop(input int d, output logic [34:0] v);
    if (d == 0) v = q0.pop_front();
    else        v = q1.pop_front();
  endtask

  task automatic basic_test(input int d);
    out_ready[d] = 1'b1;
    put(d, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    @(negedge clk);
    check($sformatf("basic_rdy%0d", d), in_ready[d], 1);
    step();
    put(d, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    @(negedge clk);
    check($sformatf("basic0_valid%0d", d), out_valid[d], 1);
    check($sformatf("basic0_res%0d", d), obs(d), {1'b1, 1'b0, 1'b1, 32'h0000_0000});
    step();
    in_valid[d] = 1'b0;
    @(negedge clk);
    check($sformatf("basic1_valid%0d", d), out_valid[d], 1);
    check($sformatf("basic1_res%0d", d), obs(d), {1'b0, 1'b1, 1'b0, 32'h8000_0000});
    step();
    @(negedge clk);
    check($sformatf("basic_drain%0d", d), out_valid[d], 0);
    step();
  endtask

  task automatic skid_test();
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic        ci[3];
    for (int i = 0; i < 3; i++) begin
      a[i] = pick(); b[i] = pick(); ci[i] = 1'($urandom_range(0, 1));
    end
    out_ready[0] = 1'b0;
    put(0, a[0], b[0], ci[0]);
    step();
    put(0, a[1], b[1], ci[1]);
    @(negedge clk);
    check("skid_rdy_busy", in_ready[0], 1);
    step();
    put(0, a[2], b[2], ci[2]);
    @(negedge clk);
    check("skid_rdy_full", in_ready[0], 0);
    check("skid_r1_valid", out_valid[0], 1);
    check("skid_r1", obs(0), model(a[0], b[0], ci[0]));
    out_ready[0] = 1'b1;
    #1;
    check("skid_no_comb_path", in_ready[0], 0);
    step();
    @(negedge clk);
    check("skid_r2_valid", out_valid[0], 1);
    check("skid_r2", obs(0), model(a[1], b[1], ci[1]));
    check("skid_rdy_again", in_ready[0], 1);
    step();
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("skid_r3_valid", out_valid[0], 1);
    check("skid_r3", obs(0), model(a[2], b[2], ci[2]));
    step();
    @(negedge clk);
    check("skid_drain", out_valid[0], 0);
    step();
  endtask

  task automatic noskid_test();
    logic [31:0] a [2];
    logic [31:0] b [2];
    for (int i = 0; i < 2; i++) begin
      a[i] = pick(); b[i] = pick();
    end
    out_ready[1] = 1'b0;
    put(1, a[0], b[0], 1'b0);
    step();
    put(1, a[1], b[1], 1'b1);
    @(negedge clk);
    check("nskid_rdy_stall", in_ready[1], 0);
    check("nskid_r1", obs(1), model(a[0], b[0], 1'b0));
    out_ready[1] = 1'b1;
    #1;
    check("nskid_rdy_comb", in_ready[1], 1);
    step();
    in_valid[1] = 1'b0;
    @(negedge clk);
    check("nskid_r2_valid", out_valid[1], 1);
    check("nskid_r2", obs(1), model(a[1], b[1], 1'b1));
    step();
    @(negedge clk);
    check("nskid_drain", out_valid[1], 0);
    step();
  endtask

  task automatic flush_test(input int d);
    logic [31:0] a [4];
    logic [31:0] b [4];
    for (int i = 0; i < 4; i++) begin
      a[i] = pick(); b[i] = pick();
    end
    out_ready[d] = 1'b0;
    put(d, a[0], b[0], 1'b0);
    step();
    in_valid[d] = 1'b0;
    if (d == 0) begin
      put(d, a[1], b[1], 1'b0);
      step();
      in_valid[d] = 1'b0;
    end
    @(negedge clk);
    check($sformatf("flush_pre_valid%0d", d), out_valid[d], 1);
    step();
    put(d, a[2], b[2], 1'b0);
    flush[d]     = 1'b1;
    out_ready[d] = 1'b1;
    step();
    flush[d]     = 1'b0;
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b0;
    @(negedge clk);
    check($sformatf("flush_valid%0d", d), out_valid[d], 0);
    check($sformatf("flush_ready%0d", d), in_ready[d], 1);
    step();
    put(d, a[3], b[3], 1'b1);
    out_ready[d] = 1'b1;
    step();
    in_valid[d] = 1'b0;
    @(negedge clk);
    check($sformatf("flush_post_valid%0d", d), out_valid[d], 1);
    check($sformatf("flush_post_res%0d", d), obs(d), model(a[3], b[3], 1'b1));
    step();
    @(negedge clk);
    check($sformatf("flush_post_drain%0d", d), out_valid[d], 0);
    step();
  endtask

  task automatic reset_test();
    logic [31:0] a;
    logic [31:0] b;
    for (int d = 0; d < 2; d++) begin
      out_ready[d] = 1'b0;
      put(d, pick(), pick(), 1'b0);
    end
    step();
    for (int d = 0; d < 2; d++) in_valid[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check($sformatf("arst_pre_valid%0d", d), out_valid[d], 1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("arst_valid%0d", d), out_valid[d], 0);
      check($sformatf("arst_res%0d", d), obs(d), 35'd0);
      check($sformatf("arst_ready%0d", d), in_ready[d], 1);
    end
    #1;
    rst_n = 1'b1;
    step();
    a = pick();
    b = pick();
    for (int d = 0; d < 2; d++) begin
      out_ready[d] = 1'b1;
      put(d, a, b, 1'b1);
    end
    step();
    for (int d = 0; d < 2; d++) in_valid[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("arst_post_valid%0d", d), out_valid[d], 1);
      check($sformatf("arst_post_res%0d", d), obs(d), model(a, b, 1'b1));
    end
    step();
  endtask

  task automatic rand_run(input int d, input int n);
    int rcv;
    bit done;
    rcv  = 0;
    done = 1'b0;
    fork
      begin : drv
        for (int i = 0; i < n; i++) begin
          logic [31:0] a;
          logic [31:0] b;
          logic        ci;
          bit          acc;
          repeat ($urandom_range(0, 2)) step();
          a  = pick();
          b  = pick();
          ci = 1'($urandom_range(0, 1));
          put(d, a, b, ci);
          acc = 1'b0;
          for (int w = 0; w < 2000 && !acc; w++) begin
            @(negedge clk);
            acc = in_ready[d];
            @(posedge clk);
          end
          check($sformatf("rand_accept%0d", d), acc, 1);
          if (!acc) break;
          push(d, model(a, b, ci));
          #1;
          in_valid[d] = 1'b0;
        end
      end
      begin : rdy
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready[d] = ($urandom_range(0, 99) < 65);
        end
      end
      begin : mon
        logic [34:0] prev;
        logic [34:0] exp;
        bit          hold;
        int          cyc;
        hold = 1'b0;
        prev = '0;
        cyc  = 0;
        while (rcv < n && cyc < 80000) begin
          @(negedge clk);
          cyc++;
          if (hold) begin
            check($sformatf("hold_valid%0d", d), out_valid[d], 1);
            check($sformatf("hold_data%0d", d), obs(d), prev);
          end
          if (out_valid[d] && out_ready[d]) begin
            if (qsize(d) == 0) begin
              check($sformatf("rand_unexpected%0d", d), out_valid[d], 0);
            end else begin
              pop(d, exp);
              check($sformatf("rand_res%0d", d), obs(d), exp);
            end
            rcv++;
          end
          hold = out_valid[d] && !out_ready[d];
          prev = obs(d);
        end
        check($sformatf("rand_count%0d", d), rcv, n);
        check($sformatf("rand_leftover%0d", d), qsize(d), 0);
        done = 1'b1;
      end
    join
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      flush[d]     = 1'b0;
      c0[d]        = 1'b0;
      gk[d]        = '0;
      ps[d]        = '0;
      out_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_valid%0d", d), out_valid[d], 0);
      check($sformatf("rst_res%0d", d), obs(d), 35'd0);
      check($sformatf("rst_ready%0d", d), in_ready[d], 1);
    end
    step();
    rst_n = 1'b1;
    step();

    for (int d = 0; d < 2; d++) basic_test(d);
    skid_test();
    noskid_test();
    for (int d = 0; d < 2; d++) flush_test(d);
    reset_test();

    fork
      rand_run(0, 10000);
      rand_run(1, 10000);
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
